// File: rtl/stream_rr_arb.sv
// Round-robin merge of N_SRC valid/ready payload streams with packet locking.
// Output is purely combinational from the inputs and the grant state.
module stream_rr_arb #(
  parameter int  N_SRC    = 4,
  parameter type PLD_TYPE = logic,
  parameter int  ID_W     = (N_SRC > 1) ? $clog2(N_SRC) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  PLD_TYPE          s_pld [N_SRC],
  input  logic [N_SRC-1:0] s_vld,
  input  logic [N_SRC-1:0] s_last,
  output logic [N_SRC-1:0] s_rdy,
  output PLD_TYPE          m_pld,
  output logic             m_last,
  output logic [ID_W-1:0]  m_id,
  output logic             m_vld,
  input  logic             m_rdy
);

  typedef enum logic [1:0] {IDLE, HOLD, PKT} st_e;

  st_e             r_st, w_st_nxt;
  logic [ID_W-1:0] r_gnt, r_ptr, w_gnt_nxt, w_ptr_nxt;
  logic [ID_W-1:0] w_win, w_sel;
  logic            w_found, w_sel_ok, w_xfer;

  // Modulo-N_SRC increment; never steps into unused codes.
  function automatic logic [ID_W-1:0] inc(input logic [ID_W-1:0] x);
    return (int'(x) == N_SRC - 1) ? '0 : x + ID_W'(1);
  endfunction

  // Scan from ptr downward-last so the first valid index after ptr wins.
  always_comb begin
    w_found = 1'b0;
    w_win   = r_ptr;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      int idx;
      idx = int'(r_ptr) + k;
      if (idx >= N_SRC) idx = idx - N_SRC;
      if (s_vld[idx]) begin
        w_found = 1'b1;
        w_win   = ID_W'(idx);
      end
    end
  end

  always_comb begin
    w_sel    = (r_st == IDLE) ? w_win : r_gnt;
    w_sel_ok = (r_st != IDLE) || w_found;
    m_pld    = s_pld[w_sel];
    m_last   = s_last[w_sel];
    m_id     = w_sel;
    m_vld    = !rst && w_sel_ok && s_vld[w_sel];
    s_rdy    = '0;
    if (!rst && w_sel_ok) s_rdy[w_sel] = m_rdy;
    w_xfer   = m_vld && m_rdy;
  end

  always_comb begin
    w_st_nxt  = r_st;
    w_gnt_nxt = r_gnt;
    w_ptr_nxt = r_ptr;
    case (r_st)
      IDLE: begin
        if (w_found) begin
          if (w_xfer && m_last) begin
            w_ptr_nxt = inc(w_win);
          end else begin
            // Lock the winner: a presented but unaccepted beat must not change.
            w_gnt_nxt = w_win;
            w_st_nxt  = w_xfer ? PKT : HOLD;
          end
        end
      end
      HOLD, PKT: begin
        if (w_xfer) begin
          if (m_last) begin
            w_st_nxt  = IDLE;
            w_ptr_nxt = inc(r_gnt);
          end else begin
            w_st_nxt  = PKT;
          end
        end
      end
      default: w_st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_st  <= IDLE;
      r_gnt <= '0;
      r_ptr <= '0;
    end else begin
      r_st  <= w_st_nxt;
      r_gnt <= w_gnt_nxt;
      r_ptr <= w_ptr_nxt;
    end
  end

endmodule

// File: tb/tb_stream_rr_arb.sv
// Bench for stream_rr_arb: 4-source and 3-source instances driven in lockstep,
// each compared every cycle against a lock/owner/pointer reference model.
module tb_stream_rr_arb;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       t_rst;
  logic [3:0] t_vld, t_last;
  logic       t_rdy;
  logic [7:0] t_pld  [4];
  logic [7:0] t_pld3 [3];

  logic [7:0] o4_pld;  logic o4_last; logic [1:0] o4_id; logic o4_vld; logic [3:0] o4_rdy;
  logic [7:0] o3_pld;  logic o3_last; logic [1:0] o3_id; logic o3_vld; logic [2:0] o3_rdy;

  int checks   = 0;
  int failures = 0;

  // Reference model: either locked to an owner, or free with a rr pointer.
  int         m_ptr  [2];
  int         m_own  [2];
  bit         m_lock [2];
  logic [3:0] acc;
  int         on  [4];
  int         rem [4];

  always_comb for (int i = 0; i < 3; i++) t_pld3[i] = t_pld[i];

  stream_rr_arb #(.N_SRC(4), .PLD_TYPE(logic [7:0])) dut4 (
    .clk(clk), .rst(t_rst), .s_pld(t_pld), .s_vld(t_vld), .s_last(t_last),
    .s_rdy(o4_rdy), .m_pld(o4_pld), .m_last(o4_last), .m_id(o4_id),
    .m_vld(o4_vld), .m_rdy(t_rdy));

  stream_rr_arb #(.N_SRC(3), .PLD_TYPE(logic [7:0])) dut3 (
    .clk(clk), .rst(t_rst), .s_pld(t_pld3), .s_vld(t_vld[2:0]), .s_last(t_last[2:0]),
    .s_rdy(o3_rdy), .m_pld(o3_pld), .m_last(o3_last), .m_id(o3_id),
    .m_vld(o3_vld), .m_rdy(t_rdy));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void mdl_sel(input int d, output int sel, output bit any);
    int n;
    n   = (d == 0) ? 4 : 3;
    any = 1'b0;
    sel = m_ptr[d];
    if (m_lock[d]) begin
      sel = m_own[d];
      any = 1'b1;
    end else begin
      for (int k = 0; k < n; k++) begin
        int i;
        i = (m_ptr[d] + k) % n;
        if (!any && t_vld[i]) begin any = 1'b1; sel = i; end
      end
    end
  endfunction

  task automatic settle();
    #1;
    for (int d = 0; d < 2; d++) begin
      int sel; bit any; logic ev; logic [3:0] er;
      mdl_sel(d, sel, any);
      ev = !t_rst && any && t_vld[sel];
      er = (!t_rst && any && t_rdy) ? 4'(1 << sel) : 4'b0;
      if (d == 0) begin
        chk("m_vld4", 32'(o4_vld), 32'(ev));
        chk("s_rdy4", 32'(o4_rdy), 32'(er));
        if (ev) begin
          chk("m_id4",   32'(o4_id),   32'(sel));
          chk("m_pld4",  32'(o4_pld),  32'(t_pld[sel]));
          chk("m_last4", 32'(o4_last), 32'(t_last[sel]));
        end
      end else begin
        chk("m_vld3", 32'(o3_vld), 32'(ev));
        chk("s_rdy3", 32'(o3_rdy), 32'(er[2:0]));
        if (ev) begin
          chk("m_id3",   32'(o3_id),   32'(sel));
          chk("m_pld3",  32'(o3_pld),  32'(t_pld[sel]));
          chk("m_last3", 32'(o3_last), 32'(t_last[sel]));
        end
      end
    end
  endtask

  task automatic adv();
    @(posedge clk);
    for (int d = 0; d < 2; d++) begin
      int sel; bit any; bit xfer; int n;
      n = (d == 0) ? 4 : 3;
      mdl_sel(d, sel, any);
      xfer = !t_rst && any && t_vld[sel] && t_rdy;
      if (d == 0) acc = xfer ? 4'(1 << sel) : 4'b0;
      if (t_rst) begin
        m_ptr[d] = 0; m_lock[d] = 1'b0; m_own[d] = 0;
      end else if (any) begin
        if (xfer && t_last[sel]) begin
          m_lock[d] = 1'b0;
          m_ptr[d]  = (sel + 1) % n;
        end else begin
          m_lock[d] = 1'b1;
          m_own[d]  = sel;
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    t_rst = 1'b1; t_vld = 4'hF; t_last = 4'hF; t_rdy = 1'b1;
    settle();
    chk("rst_vld4", 32'(o4_vld), 0);
    chk("rst_rdy4", 32'(o4_rdy), 0);
    adv();
    t_rst = 1'b0; t_vld = 4'h0; t_last = 4'h0; t_rdy = 1'b0;
  endtask

  initial begin
    t_rst = 1'b1; t_vld = '0; t_last = '0; t_rdy = 1'b0;
    for (int i = 0; i < 4; i++) t_pld[i] = 8'(8'h10 * i);
    for (int d = 0; d < 2; d++) begin m_ptr[d] = 0; m_own[d] = 0; m_lock[d] = 1'b0; end
    acc = '0;
    @(negedge clk);

    // Source 2: 3-beat packet, then pointer should favour source 3.
    do_reset();
    t_rdy = 1'b1;
    for (int b = 0; b < 3; b++) begin
      t_vld = 4'b0100; t_last = (b == 2) ? 4'b0100 : 4'b0000; t_pld[2] = 8'(8'hA0 + b);
      settle();
      chk("t1_vld", 32'(o4_vld), 1);
      chk("t1_id",  32'(o4_id), 2);
      chk("t1_pld", 32'(o4_pld), 32'(8'hA0 + b));
      adv();
    end
    t_vld = 4'hF; t_last = 4'hF;
    settle(); chk("t1_ptr3", 32'(o4_id), 3); adv();

    // All sources streaming single beats: strict rotation, no bubbles.
    do_reset();
    t_vld = 4'hF; t_last = 4'hF; t_rdy = 1'b1;
    for (int c = 0; c < 8; c++) begin
      settle();
      chk("t2_vld", 32'(o4_vld), 1);
      chk("t2_id",  32'(o4_id), 32'(c % 4));
      adv();
    end

    // Held beat from source 1 must not be preempted by source 0.
    do_reset();
    t_vld = 4'b0010; t_last = 4'b0010; t_pld[1] = 8'h55; t_rdy = 1'b0;
    settle(); chk("t3_id0", 32'(o4_id), 1); adv();
    t_vld = 4'b0011; t_last = 4'b0011;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("t3_id",  32'(o4_id), 1);
      chk("t3_pld", 32'(o4_pld), 32'h55);
      chk("t3_rdy", 32'(o4_rdy), 0);
      adv();
    end
    t_rdy = 1'b1;
    settle(); chk("t3_xid", 32'(o4_id), 1); chk("t3_xrdy", 32'(o4_rdy), 32'h2); adv();
    t_vld = 4'b0001;
    settle(); chk("t3_next", 32'(o4_id), 0); adv();

    // Source 3 bubbles mid-packet; source 0 stays blocked.
    do_reset();
    t_rdy = 1'b1; t_vld = 4'b1000; t_last = 4'b0000; t_pld[3] = 8'hC0;
    settle(); chk("t4_id0", 32'(o4_id), 3); adv();
    t_vld = 4'b0001; t_last = 4'b0001;
    for (int c = 0; c < 2; c++) begin
      settle();
      chk("t4_bvld",  32'(o4_vld), 0);
      chk("t4_brdy0", 32'(o4_rdy[0]), 0);
      adv();
    end
    for (int b = 1; b < 4; b++) begin
      t_vld = 4'b1001; t_last = (b == 3) ? 4'b1001 : 4'b0001; t_pld[3] = 8'(8'hC0 + b);
      settle(); chk("t4_id", 32'(o4_id), 3); chk("t4_pld", 32'(o4_pld), 32'(8'hC0 + b)); adv();
    end
    t_vld = 4'b0001;
    settle(); chk("t4_after", 32'(o4_id), 0); adv();

    // Three sources: pointer wraps from 2 back to 0.
    do_reset();
    t_rdy = 1'b1; t_vld = 4'b0100; t_last = 4'b0000;
    settle(); adv();
    t_last = 4'b0100;
    settle(); chk("t5_id2", 32'(o3_id), 2); adv();
    t_vld = 4'b0101; t_last = 4'b0101;
    settle(); chk("t5_wrap", 32'(o3_id), 0); chk("t5_vld", 32'(o3_vld), 1); adv();

    // Reset mid-packet abandons the lock.
    do_reset();
    t_rdy = 1'b1; t_vld = 4'b0001; t_last = 4'b0000;
    settle(); chk("t6_id0", 32'(o4_id), 0); adv();
    t_rst = 1'b1; t_vld = 4'b0011; t_last = 4'b0010;
    settle(); chk("t6_rvld", 32'(o4_vld), 0); chk("t6_rrdy", 32'(o4_rdy), 0); adv();
    t_rst = 1'b0; t_vld = 4'b0010;
    settle(); chk("t6_id1", 32'(o4_id), 1); chk("t6_vld", 32'(o4_vld), 1); adv();
    t_vld = 4'b0001; t_last = 4'b0001;
    settle(); chk("t6_free", 32'(o4_id), 0); adv();

    // Randomized traffic, protocol-compliant with respect to the 4-source instance.
    do_reset();
    acc = '0;
    for (int i = 0; i < 4; i++) begin on[i] = 0; rem[i] = 0; end
    for (int c = 0; c < 500; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (acc[i]) begin on[i] = 0; rem[i]--; end
        if (on[i] == 0 && $urandom_range(0, 2) != 0) begin
          if (rem[i] <= 0) rem[i] = int'($urandom_range(1, 3));
          on[i] = 1;
          t_pld[i] = 8'($urandom);
        end
        t_vld[i]  = (on[i] != 0);
        t_last[i] = (rem[i] == 1);
      end
      t_rdy = ($urandom_range(0, 3) != 0);
      t_rst = ($urandom_range(0, 63) == 0);
      settle();
      adv();
    end
    t_rst = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
